// File: rtl/lattice_bram_scheduler.sv
// Shares the lattice BRAM port between display reads and physics accesses; runs one physics step per frame.
// Latency: grant in cycle N -> BRAM port registers in N+1 -> read data/valid on the owner's outputs in N+1+READ_LATENCY.
// Backpressure: the display is never stalled; physics sees ready only while a step runs and the display is idle.
module lattice_bram_scheduler #(
    parameter int BRAM_DEPTH   = 31570,
    parameter int DATA_W       = 72,
    parameter int READ_LATENCY = 2,
    parameter int ADDR_W       = $clog2(BRAM_DEPTH)
) (
    input  logic              pixel_clk_in,
    input  logic              rst_in,
    input  logic              enable_in,
    input  logic              new_frame_in,
    output logic              step_start_out,
    input  logic              step_done_in,
    output logic              step_busy_out,
    output logic [15:0]       step_count_out,
    output logic              overrun_out,
    input  logic              clear_overrun_in,
    input  logic              disp_active_in,
    input  logic [ADDR_W-1:0] disp_addr_in,
    output logic              disp_valid_out,
    output logic [DATA_W-1:0] disp_data_out,
    input  logic              phys_req_valid_in,
    output logic              phys_req_ready_out,
    input  logic              phys_req_we_in,
    input  logic [ADDR_W-1:0] phys_req_addr_in,
    input  logic [DATA_W-1:0] phys_req_wdata_in,
    output logic              phys_rsp_valid_out,
    output logic [DATA_W-1:0] phys_rsp_data_out,
    output logic [ADDR_W-1:0] bram_addr_out,
    output logic              bram_we_out,
    output logic [DATA_W-1:0] bram_din_out,
    input  logic [DATA_W-1:0] bram_dout_in
);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_pending;
    logic              w_pending_nxt;
    logic              w_start;
    logic              w_count_inc;
    logic              w_ovr_set;
    logic              w_frame_ok;
    logic              r_step_start;
    logic [15:0]       r_step_count;
    logic              r_overrun;

    logic              w_phys_rdy;
    logic              w_phys_go;
    logic              w_rd_go;
    logic [ADDR_W-1:0] r_bram_addr;
    logic              r_bram_we;
    logic [DATA_W-1:0] r_bram_din;
    // Slot k describes the read issued k+1 cycles ago; owner bit 1 = physics.
    logic [READ_LATENCY:0] r_tag_vld;
    logic [READ_LATENCY:0] r_tag_phys;

    // A frame only counts when new steps are permitted.
    assign w_frame_ok = new_frame_in && enable_in;

    // Step FSM state register.
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next state: leave RUN only when a step finishes with nothing waiting to launch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_frame_ok) w_state_nxt = S_RUN;
            S_RUN:   if (step_done_in && !(r_pending && enable_in) && !w_frame_ok) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: done is handled before a coincident frame, so that frame relaunches instead of overrunning.
    always_comb begin
        w_start       = 1'b0;
        w_count_inc   = 1'b0;
        w_ovr_set     = 1'b0;
        w_pending_nxt = r_pending;
        case (r_state)
            S_IDLE: begin
                w_start       = w_frame_ok;
                w_pending_nxt = 1'b0;
            end
            S_RUN: begin
                if (step_done_in) begin
                    w_count_inc = 1'b1;
                    if (r_pending && enable_in) begin
                        w_start       = 1'b1;
                        w_pending_nxt = w_frame_ok;
                    end else begin
                        w_start       = w_frame_ok;
                        w_pending_nxt = 1'b0;
                    end
                end else if (w_frame_ok) begin
                    w_ovr_set     = r_pending;
                    w_pending_nxt = 1'b1;
                end
            end
            default: w_pending_nxt = 1'b0;
        endcase
    end

    // Step bookkeeping registers; a new overrun beats a simultaneous clear.
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_pending    <= 1'b0;
            r_step_start <= 1'b0;
            r_step_count <= '0;
            r_overrun    <= 1'b0;
        end else begin
            r_pending    <= w_pending_nxt;
            r_step_start <= w_start;
            if (w_count_inc) r_step_count <= r_step_count + 16'd1;
            if (w_ovr_set)             r_overrun <= 1'b1;
            else if (clear_overrun_in) r_overrun <= 1'b0;
        end
    end

    assign step_start_out = r_step_start;
    assign step_busy_out  = (r_state == S_RUN);
    assign step_count_out = r_step_count;
    assign overrun_out    = r_overrun;

    // Display owns the port whenever it asks; physics fills otherwise-idle cycles during a step.
    assign w_phys_rdy         = (r_state == S_RUN) && !disp_active_in;
    assign w_phys_go          = phys_req_valid_in && w_phys_rdy;
    assign w_rd_go            = disp_active_in || (w_phys_go && !phys_req_we_in);
    assign phys_req_ready_out = w_phys_rdy;

    // Registered BRAM port; address and data hold when nobody uses the port.
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_bram_addr <= '0;
            r_bram_we   <= 1'b0;
            r_bram_din  <= '0;
        end else begin
            r_bram_we <= w_phys_go && phys_req_we_in;
            if (disp_active_in) begin
                r_bram_addr <= disp_addr_in;
            end else if (w_phys_go) begin
                r_bram_addr <= phys_req_addr_in;
                r_bram_din  <= phys_req_wdata_in;
            end
        end
    end

    assign bram_addr_out = r_bram_addr;
    assign bram_we_out   = r_bram_we;
    assign bram_din_out  = r_bram_din;

    // Read tags travel alongside the BRAM pipeline so each result returns only to its requester.
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_tag_vld  <= '0;
            r_tag_phys <= '0;
        end else begin
            r_tag_vld  <= {r_tag_vld[READ_LATENCY-1:0], w_rd_go};
            r_tag_phys <= {r_tag_phys[READ_LATENCY-1:0], !disp_active_in};
        end
    end

    // The BRAM output register supplies the data; it is gated so idle outputs read as zero.
    assign disp_valid_out     = r_tag_vld[READ_LATENCY] && !r_tag_phys[READ_LATENCY];
    assign phys_rsp_valid_out = r_tag_vld[READ_LATENCY] &&  r_tag_phys[READ_LATENCY];
    assign disp_data_out      = disp_valid_out     ? bram_dout_in : '0;
    assign phys_rsp_data_out  = phys_rsp_valid_out ? bram_dout_in : '0;

endmodule

// File: tb/tb_lattice_bram_scheduler.sv
// Bench for lattice_bram_scheduler: directed steps plus a random phase, all scored against a cycle-level model.
// The model keeps a memory image and a queue of expected read returns stamped with their due cycle.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_lattice_bram_scheduler;
    localparam int DEPTH = 31570;
    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = 72;
    localparam int RL    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable, new_frame, step_start, step_done, step_busy, overrun, clear_ovr;
    logic [15:0]   step_count;
    logic          disp_active, disp_valid;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          preq_vld, preq_rdy, preq_we, prsp_vld;
    logic [AW-1:0] preq_addr;
    logic [DW-1:0] preq_wdata, prsp_data;
    logic [AW-1:0] bram_addr;
    logic          bram_we;
    logic [DW-1:0] bram_din, bram_dout;

    always #5 clk = ~clk;

    lattice_bram_scheduler dut (
        .pixel_clk_in(clk), .rst_in(rst_n), .enable_in(enable), .new_frame_in(new_frame),
        .step_start_out(step_start), .step_done_in(step_done), .step_busy_out(step_busy),
        .step_count_out(step_count), .overrun_out(overrun), .clear_overrun_in(clear_ovr),
        .disp_active_in(disp_active), .disp_addr_in(disp_addr), .disp_valid_out(disp_valid),
        .disp_data_out(disp_data), .phys_req_valid_in(preq_vld), .phys_req_ready_out(preq_rdy),
        .phys_req_we_in(preq_we), .phys_req_addr_in(preq_addr), .phys_req_wdata_in(preq_wdata),
        .phys_rsp_valid_out(prsp_vld), .phys_rsp_data_out(prsp_data), .bram_addr_out(bram_addr),
        .bram_we_out(bram_we), .bram_din_out(bram_din), .bram_dout_in(bram_dout)
    );

    // BRAM: unwritten cells read back their own address; two-cycle read from the registered address.
    logic [DW-1:0] bmem [DEPTH];
    bit            bwr  [DEPTH];
    logic [DW-1:0] brd1;
    always @(posedge clk) begin
        if (bram_we) begin
            bmem[bram_addr] <= bram_din;
            bwr[bram_addr]  <= 1'b1;
        end
        brd1      <= bwr[bram_addr] ? bmem[bram_addr] : DW'(bram_addr);
        bram_dout <= brd1;
    end

    // Reference model state.
    typedef struct { int due; bit phys; logic [DW-1:0] dat; } rsp_t;
    rsp_t          exp_q[$];
    logic [DW-1:0] rmem [DEPTH];
    bit            rwr  [DEPTH];
    bit            m_run, m_start, m_pend, m_ov, m_we;
    logic [15:0]   m_cnt;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    int            cyc_n = 0;
    int            n_cmp = 0;
    int            n_err = 0;

    function automatic logic [DW-1:0] ref_rd(int a);
        return rwr[a] ? rmem[a] : DW'(a);
    endfunction

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_start = 0; m_pend = 0; m_ov = 0; m_we = 0;
        m_cnt = '0; m_addr = '0; m_din = '0;
        exp_q.delete();
    endtask

    // Assert reset asynchronously mid-cycle; every output must drop at once.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_disp_valid", DW'(disp_valid), '0);
        chk("rst_phys_valid", DW'(prsp_vld), '0);
        chk("rst_disp_data", disp_data, '0);
        chk("rst_phys_data", prsp_data, '0);
        chk("rst_start", DW'(step_start), '0);
        chk("rst_busy", DW'(step_busy), '0);
        chk("rst_count", DW'(step_count), '0);
        chk("rst_overrun", DW'(overrun), '0);
        chk("rst_ready", DW'(preq_rdy), '0);
        chk("rst_bram_addr", DW'(bram_addr), '0);
        chk("rst_bram_we", DW'(bram_we), '0);
        chk("rst_bram_din", bram_din, '0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive, score the cycle against the model, then advance the model.
    task automatic cycle(bit da, int daddr, bit pv, bit pwe, int paddr, logic [DW-1:0] wd,
                         bit nf, bit en, bit dn, bit clr);
        bit            go, fok, ovset, n_run, n_start, n_pend, n_ov, n_we, e_dv, e_pv;
        logic [15:0]   n_cnt;
        logic [AW-1:0] n_addr;
        logic [DW-1:0] n_din, e_dat;
        rsp_t          r;
        disp_active = da; disp_addr = AW'(daddr);
        preq_vld = pv; preq_we = pwe; preq_addr = AW'(paddr); preq_wdata = wd;
        new_frame = nf; enable = en; step_done = dn; clear_ovr = clr;
        #1;
        chk("phys_ready", DW'(preq_rdy), DW'(m_run && !da));
        // Port: display first, physics only during a step.
        go = pv && m_run && !da;
        n_we = go && pwe; n_addr = m_addr; n_din = m_din;
        if (da) begin
            n_addr = AW'(daddr);
            r.due = cyc_n + 1 + RL; r.phys = 0; r.dat = ref_rd(daddr); exp_q.push_back(r);
        end else if (go) begin
            n_addr = AW'(paddr); n_din = wd;
            if (pwe) begin
                rmem[paddr] = wd; rwr[paddr] = 1;
            end else begin
                r.due = cyc_n + 1 + RL; r.phys = 1; r.dat = ref_rd(paddr); exp_q.push_back(r);
            end
        end
        // Step sequencing rules.
        fok = nf && en; n_run = m_run; n_pend = m_pend; n_cnt = m_cnt; n_start = 0; ovset = 0;
        if (!m_run) begin
            if (fok) begin n_start = 1; n_run = 1; end
        end else if (dn) begin
            n_cnt = m_cnt + 16'd1;
            if (m_pend && en)  begin n_start = 1; n_pend = fok; end
            else if (fok)      begin n_start = 1; n_pend = 0; end
            else               begin n_run = 0; n_pend = 0; end
        end else if (fok) begin
            ovset = m_pend; n_pend = 1;
        end
        n_ov = ovset ? 1'b1 : (clr ? 1'b0 : m_ov);
        @(negedge clk);
        e_dv = 0; e_pv = 0; e_dat = '0;
        if (exp_q.size() != 0 && exp_q[0].due == cyc_n) begin
            r = exp_q.pop_front();
            if (r.phys) e_pv = 1; else e_dv = 1;
            e_dat = r.dat;
        end
        chk("disp_valid", DW'(disp_valid), DW'(e_dv));
        chk("phys_rsp_valid", DW'(prsp_vld), DW'(e_pv));
        if (e_dv) chk("disp_data", disp_data, e_dat);
        if (e_pv) chk("phys_rsp_data", prsp_data, e_dat);
        chk("step_start", DW'(step_start), DW'(m_start));
        chk("step_busy", DW'(step_busy), DW'(m_run));
        chk("step_count", DW'(step_count), DW'(m_cnt));
        chk("overrun", DW'(overrun), DW'(m_ov));
        chk("bram_addr", DW'(bram_addr), DW'(m_addr));
        chk("bram_we", DW'(bram_we), DW'(m_we));
        if (m_we) chk("bram_din", bram_din, m_din);
        @(posedge clk); #1;
        m_run = n_run; m_start = n_start; m_pend = n_pend; m_ov = n_ov; m_cnt = n_cnt;
        m_we = n_we; m_addr = n_addr; m_din = n_din;
        cyc_n++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, '0, 0, 1, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 0; new_frame = 0; step_done = 0; clear_ovr = 0;
        disp_active = 0; disp_addr = '0; preq_vld = 0; preq_we = 0; preq_addr = '0; preq_wdata = '0;
        @(posedge clk); #1;
        do_reset();

        // Display-only streaming reads; physics is held off while idle.
        for (int i = 0; i < 8; i++) cycle(1, i, 1, 0, i + 100, '0, 0, 1, 0, 0);
        idle(4);

        // One step: frame -> start pulse and busy -> done -> back to idle with count 1.
        cycle(0, 0, 0, 0, 0, '0, 1, 1, 0, 0);
        chk("start_after_frame", DW'(step_start), 1);
        idle(2);
        cycle(0, 0, 0, 0, 0, '0, 0, 1, 1, 0);
        idle(1);
        chk("count_after_step", DW'(step_count), 1);
        chk("busy_after_done", DW'(step_busy), 0);

        // Frame with enable low starts nothing.
        cycle(0, 0, 0, 0, 0, '0, 1, 0, 0, 0);
        idle(1);
        chk("no_start_disabled", DW'(step_busy), 0);

        // Overrun: two extra frames during a step, immediate relaunch on done, then clear.
        cycle(0, 0, 0, 0, 0, '0, 1, 1, 0, 0);
        idle(1);
        cycle(0, 0, 0, 0, 0, '0, 1, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, '0, 1, 1, 0, 0);
        idle(1);
        chk("overrun_set", DW'(overrun), 1);
        cycle(0, 0, 0, 0, 0, '0, 0, 1, 1, 0);
        chk("relaunch_pulse", DW'(step_start), 1);
        chk("relaunch_busy", DW'(step_busy), 1);
        cycle(0, 0, 0, 0, 0, '0, 0, 1, 0, 1);
        chk("overrun_cleared", DW'(overrun), 0);

        // Interleaved physics read of 10 then display read of 20.
        cycle(0, 0, 1, 0, 10, '0, 0, 1, 0, 0);
        cycle(1, 20, 0, 0, 0, '0, 0, 1, 0, 0);
        idle(1);
        chk("ilv_phys_valid", DW'(prsp_vld), 1);
        chk("ilv_phys_data", prsp_data, 72'd10);
        chk("ilv_disp_quiet", DW'(disp_valid), 0);
        idle(1);
        chk("ilv_disp_valid", DW'(disp_valid), 1);
        chk("ilv_disp_data", disp_data, 72'd20);
        chk("ilv_phys_quiet", DW'(prsp_vld), 0);

        // Write then read back; a write under display activity stalls until the display lets go.
        cycle(0, 0, 1, 1, 5, 72'hAB_ABAB_ABAB_ABAB_ABAB, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 5, '0, 0, 1, 0, 0);
        idle(2);
        chk("raw_data", prsp_data, 72'hAB_ABAB_ABAB_ABAB_ABAB);
        cycle(1, 3, 1, 1, 6, 72'hCD_CDCD_CDCD_CDCD_CDCD, 0, 1, 0, 0);
        cycle(0, 0, 1, 1, 6, 72'hCD_CDCD_CDCD_CDCD_CDCD, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 6, '0, 0, 1, 0, 0);
        idle(4);
        cycle(0, 0, 0, 0, 0, '0, 0, 1, 1, 0);
        idle(2);

        // Random traffic over a small address window so reads revisit written cells.
        for (int k = 0; k < 800; k++)
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 63),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 63),
                  DW'({$urandom(), $urandom(), $urandom()}),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
        idle(4);

        // Reset with a physics and a display read still in flight.
        cycle(0, 0, 0, 0, 0, '0, 1, 1, 0, 0);
        cycle(0, 0, 1, 0, 7, '0, 0, 1, 0, 0);
        cycle(1, 8, 0, 0, 0, '0, 0, 1, 0, 0);
        do_reset();
        idle(6);
        chk("count_after_reset", DW'(step_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lattice_bram_scheduler.md
# lattice_bram_scheduler

Time-shares the single port of the lattice density BRAM (9 × 8-bit distributions per cell, 205 × 154 grid) between the display pixel path and the physics update engine, and sequences one simulation step per video frame. It sits between the BRAM, the pixel colour calculator (display reads) and the collision/streaming engine (reads and writes). The display always wins the port. The physics engine gets the port only while a step is running and the display is idle.

## Interface
- BRAM_DEPTH, 31570, number of lattice cells; ADDR_W = $clog2(BRAM_DEPTH)
- DATA_W, 72, cell word width (9 × 8 bits)
- READ_LATENCY, 2, BRAM read latency in cycles, from registered address to valid dout

- pixel_clk_in  in  1  sole clock; all logic on its rising edge
- rst_in  in  1  asynchronous, active-low reset (0 = reset)
- enable_in  in  1  permits new simulation steps to start
- new_frame_in  in  1  one-cycle pulse at frame start
- step_start_out  out  1  one-cycle pulse that launches the physics engine
- step_done_in  in  1  one-cycle pulse from the engine when its step is complete
- step_busy_out  out  1  high while in RUN
- step_count_out  out  16  completed steps; wraps 0xFFFF→0
- overrun_out  out  1  sticky flag: a frame arrived while a step was already pending
- clear_overrun_in  in  1  clears overrun_out
- disp_active_in  in  1  display requests a read this cycle
- disp_addr_in  in  ADDR_W  display read address
- disp_valid_out  out  1  display read data valid
- disp_data_out  out  DATA_W  display read data
- phys_req_valid_in  in  1  physics request valid
- phys_req_ready_out  out  1  physics request accepted when valid && ready
- phys_req_we_in  in  1  1 = write, 0 = read
- phys_req_addr_in  in  ADDR_W  physics address
- phys_req_wdata_in  in  DATA_W  physics write data
- phys_rsp_valid_out  out  1  physics read data valid
- phys_rsp_data_out  out  DATA_W  physics read data
- bram_addr_out  out  ADDR_W  registered BRAM address
- bram_we_out  out  1  registered BRAM write enable
- bram_din_out  out  DATA_W  registered BRAM write data
- bram_dout_in  in  DATA_W  BRAM read data

## Operation
- Step FSM states:
  - IDLE: on new_frame_in && enable_in, pulse step_start_out and go to RUN.
  - RUN: on step_done_in, increment step_count_out. If pending is set, clear it, pulse step_start_out on the next cycle and stay in RUN; otherwise go to IDLE.
- pending is a 1-bit flag. It is set by new_frame_in during RUN. If new_frame_in arrives during RUN while pending is already set, set overrun_out; frames are never queued deeper than one.
- new_frame_in with enable_in low: no start and no pending. Dropping enable_in during RUN does not abort the current step, and no pending restart occurs while enable_in is low.
- When step_done_in and new_frame_in arrive in the same cycle: the done is processed first, so the step restarts immediately and overrun_out is not set.
- When clear_overrun_in and an overrun event coincide: overrun_out stays set.
- Arbitration, evaluated every cycle:
  - disp_active_in has absolute priority.
  - phys_req_ready_out = (state == RUN) && !disp_active_in, combinational.
  - An accepted physics write produces no response.
- In-flight tracking: a shift register READ_LATENCY + 1 deep carries {valid, owner} per slot. Each BRAM read result goes only to its owner. Display and physics reads can interleave freely.
- If no source uses the port in a cycle, bram_we_out = 0 and the address holds its last value.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, pending = 0, and the tag pipeline is cleared.
- Reset mid-operation: in-flight reads are discarded with no valid pulse. A write accepted in the cycle before reset need not complete.
- Cycle N, a request is granted. In cycle N+1 it appears on bram_addr_out, bram_we_out and bram_din_out.
- Read data appears on disp_* or phys_rsp_* in cycle N+1+READ_LATENCY, i.e. N+3 by default, as a one-cycle valid with registered data.
- Throughput is one access per cycle.
- step_start_out is exactly one cycle wide.
- step_busy_out is registered and rises in the cycle after the start decision.

## Test plan
- Display reads only: disp_active_in high, disp_addr_in = 0,1,2…, BRAM model returns the address as data → disp_valid_out high from cycle 3, disp_data_out = 0,1,2… in order, and phys_req_ready_out stays 0.
- Step sequencing: pulse new_frame_in with enable_in = 1 → step_start_out one cycle later and step_busy_out high. Pulse step_done_in → IDLE and step_count_out = 1.
- Overrun: two new_frame_in pulses during RUN → overrun_out = 1. Then step_done_in → step_start_out fires again immediately. clear_overrun_in → overrun_out = 0.
- Interleaving: the physics engine reads addr 10 at N, the display reads addr 20 at N+1 → phys_rsp_data_out = 10 at N+3 and disp_data_out = 20 at N+4, each routed to its own output only.
- Write then read: physics writes 0xAB.. to addr 5 while the display is idle, then reads addr 5 → phys_rsp_data_out = 0xAB.. The same write attempted while disp_active_in is high is stalled (ready = 0) until display inactive.
- Async reset with two reads in flight → no valid pulses afterwards, all outputs 0, and step_count_out = 0.
